// File: rtl/pipe_pulse_interval_meter_if.sv
// Interval result stream: head entry of the meter FIFO with a valid/ready handshake.
interface pipe_pulse_interval_meter_if #(
    parameter int IW = 16
);
    logic [IW-1:0] iv_data;
    logic          iv_first;
    logic          iv_valid;
    logic          iv_ready;

    modport master (
        output iv_data, iv_first, iv_valid,
        input  iv_ready
    );

    modport slave (
        input  iv_data, iv_first, iv_valid,
        output iv_ready
    );
endinterface

// File: rtl/pipe_pulse_interval_meter.sv
// Measures cycles between rising edges of the pulse line and queues the
// intervals in a first-word-fall-through FIFO with drop statistics.
module pipe_pulse_interval_meter #(
    parameter int IW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     pulse_in,
    input  logic                     clear_stats,
    pipe_pulse_interval_meter_if.master iv,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic [$clog2(DEPTH):0]   fill_level
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_e;

    state_e        state_q;
    logic          pulse_prev_q;
    logic [IW-1:0] cnt_q;

    logic          edge_det;
    logic          push;
    logic [IW:0]   cnt_inc;
    logic [IW-1:0] sat_iv;
    logic [IW:0]   push_entry;

    assign edge_det = pulse_in & ~pulse_prev_q;
    assign push     = enable & (state_q != IDLE) & edge_det;
    assign cnt_inc  = {1'b0, cnt_q} + {{IW{1'b0}}, 1'b1};
    assign sat_iv   = cnt_inc[IW] ? '1 : cnt_inc[IW-1:0];

    // Entry layout: {first, data}
    assign push_entry = (state_q == ARMED) ? {1'b1, {IW{1'b0}}}
                                           : {1'b0, sat_iv};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pulse_prev_q <= 1'b0;
        end else begin
            pulse_prev_q <= pulse_in;
            if (!enable) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: state_q <= ARMED;
                    ARMED: begin
                        if (edge_det) state_q <= RUN;
                        cnt_q <= '0;
                    end
                    RUN: begin
                        if (edge_det)        cnt_q <= '0;
                        else if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    logic [IW:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   count_q;
    logic [IW:0]   head;

    logic full;
    logic pop;
    logic push_ok;
    logic drop;

    assign full    = count_q[AW];
    assign pop     = iv.iv_valid & iv.iv_ready;
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop)     rd_q <= rd_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // A drop coincident with a clear leaves exactly one counted drop
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_stats)             drop_count <= 8'd1;
            else if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end else if (clear_stats) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    assign head        = mem_q[rd_q];
    assign iv.iv_valid = (count_q != '0);
    assign iv.iv_data  = iv.iv_valid ? head[IW-1:0] : '0;
    assign iv.iv_first = iv.iv_valid & head[IW];
    assign fill_level  = count_q;
endmodule

// File: tb/tb_pipe_pulse_interval_meter.sv
// Directed bench for pipe_pulse_interval_meter: intervals, saturation,
// FIFO full/drop behaviour, enable and reset handling.
module tb_pipe_pulse_interval_meter;
    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       pulse_in;
    logic       clear_stats;
    logic       overflow;
    logic [7:0] drop_count;
    logic [3:0] fill_level;

    logic       e4;
    logic       p4;
    logic       ovf4;
    logic [7:0] drop4;
    logic [3:0] fill4;

    int passed = 0;
    int total  = 0;

    pipe_pulse_interval_meter_if #(.IW(16)) iv ();
    pipe_pulse_interval_meter_if #(.IW(4))  iv4 ();

    pipe_pulse_interval_meter #(.IW(16), .DEPTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .pulse_in    (pulse_in),
        .clear_stats (clear_stats),
        .iv          (iv),
        .overflow    (overflow),
        .drop_count  (drop_count),
        .fill_level  (fill_level)
    );

    pipe_pulse_interval_meter #(.IW(4), .DEPTH(8)) dut4 (
        .clk         (clk),
        .reset       (reset),
        .enable      (e4),
        .pulse_in    (p4),
        .clear_stats (1'b0),
        .iv          (iv4),
        .overflow    (ovf4),
        .drop_count  (drop4),
        .fill_level  (fill4)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        pulse_in = 1'b1;
        tick(1);
        pulse_in = 1'b0;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        enable      = 1'b0;
        pulse_in    = 1'b0;
        clear_stats = 1'b0;
        iv.iv_ready = 1'b0;
        e4          = 1'b0;
        p4          = 1'b0;
        iv4.iv_ready = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (iv.iv_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", iv.iv_valid); else passed++;
        total++; if (iv.iv_data !== 16'd0) $display("FAIL rst_data: got %0d want 0", iv.iv_data); else passed++;
        total++; if (iv.iv_first !== 1'b0) $display("FAIL rst_first: got %b want 0", iv.iv_first); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", overflow); else passed++;
        total++; if (drop_count !== 8'd0) $display("FAIL rst_drop: got %0d want 0", drop_count); else passed++;
        total++; if (fill_level !== 4'd0) $display("FAIL rst_fill: got %0d want 0", fill_level); else passed++;
    endtask

    task automatic test_intervals();
        do_reset();
        iv.iv_ready = 1'b1;
        enable = 1'b1;
        tick(1);
        pulse();
        total++; if (iv.iv_valid !== 1'b1) $display("FAIL iv1_valid: got %b want 1", iv.iv_valid); else passed++;
        total++; if (iv.iv_first !== 1'b1) $display("FAIL iv1_first: got %b want 1", iv.iv_first); else passed++;
        total++; if (iv.iv_data !== 16'd0) $display("FAIL iv1_data: got %0d want 0", iv.iv_data); else passed++;
        tick(4);
        pulse();
        total++; if (iv.iv_valid !== 1'b1) $display("FAIL iv5_valid: got %b want 1", iv.iv_valid); else passed++;
        total++; if (iv.iv_first !== 1'b0) $display("FAIL iv5_first: got %b want 0", iv.iv_first); else passed++;
        total++; if (iv.iv_data !== 16'd5) $display("FAIL iv5_data: got %0d want 5", iv.iv_data); else passed++;
        tick(99);
        pulse();
        total++; if (iv.iv_valid !== 1'b1) $display("FAIL iv100_valid: got %b want 1", iv.iv_valid); else passed++;
        total++; if (iv.iv_first !== 1'b0) $display("FAIL iv100_first: got %b want 0", iv.iv_first); else passed++;
        total++; if (iv.iv_data !== 16'd100) $display("FAIL iv100_data: got %0d want 100", iv.iv_data); else passed++;
    endtask

    task automatic test_long_high();
        do_reset();
        iv.iv_ready = 1'b1;
        enable = 1'b1;
        tick(1);
        pulse_in = 1'b1;
        tick(1);
        total++; if (iv.iv_first !== 1'b1) $display("FAIL lh_first: got %b want 1", iv.iv_first); else passed++;
        total++; if (iv.iv_data !== 16'd0) $display("FAIL lh_data0: got %0d want 0", iv.iv_data); else passed++;
        tick(5);
        total++; if (iv.iv_valid !== 1'b0) $display("FAIL lh_single: got valid %b want 0", iv.iv_valid); else passed++;
        pulse_in = 1'b0;
        tick(14);
        pulse();
        total++; if (iv.iv_first !== 1'b0) $display("FAIL lh_first2: got %b want 0", iv.iv_first); else passed++;
        total++; if (iv.iv_data !== 16'd20) $display("FAIL lh_data20: got %0d want 20", iv.iv_data); else passed++;
    endtask

    task automatic test_saturate();
        do_reset();
        e4 = 1'b1;
        tick(1);
        p4 = 1'b1;
        tick(1);
        p4 = 1'b0;
        total++; if (iv4.iv_first !== 1'b1) $display("FAIL sat_first: got %b want 1", iv4.iv_first); else passed++;
        tick(29);
        p4 = 1'b1;
        tick(1);
        p4 = 1'b0;
        total++; if (fill4 !== 4'd2) $display("FAIL sat_fill: got %0d want 2", fill4); else passed++;
        iv4.iv_ready = 1'b1;
        tick(1);
        iv4.iv_ready = 1'b0;
        total++; if (iv4.iv_first !== 1'b0) $display("FAIL sat_first2: got %b want 0", iv4.iv_first); else passed++;
        total++; if (iv4.iv_data !== 4'd15) $display("FAIL sat_data: got %0d want 15", iv4.iv_data); else passed++;
    endtask

    task automatic test_overflow();
        logic [15:0] d0;
        do_reset();
        enable = 1'b1;
        tick(1);
        pulse();
        for (int i = 1; i <= 9; i++) begin
            tick(i);
            pulse();
        end
        total++; if (fill_level !== 4'd8) $display("FAIL ov_fill: got %0d want 8", fill_level); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ov_flag: got %b want 1", overflow); else passed++;
        total++; if (drop_count !== 8'd2) $display("FAIL ov_drop: got %0d want 2", drop_count); else passed++;
        d0 = iv.iv_data;
        tick(3);
        total++; if (iv.iv_data !== d0 || iv.iv_first !== 1'b1) $display("FAIL ov_stall: got %0d/%b want %0d/1", iv.iv_data, iv.iv_first, d0); else passed++;
        iv.iv_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (iv.iv_valid !== 1'b1 || iv.iv_first !== (k == 0) || iv.iv_data !== ((k == 0) ? 16'd0 : 16'(k + 1)))
                $display("FAIL ov_drain%0d: got %b/%b/%0d want 1/%b/%0d", k, iv.iv_valid, iv.iv_first, iv.iv_data, (k == 0), (k == 0) ? 0 : k + 1);
            else passed++;
            tick(1);
        end
        total++; if (iv.iv_valid !== 1'b0 || fill_level !== 4'd0) $display("FAIL ov_empty: got %b/%0d want 0/0", iv.iv_valid, fill_level); else passed++;
    endtask

    task automatic test_full_pop();
        do_reset();
        enable = 1'b1;
        tick(1);
        pulse();
        repeat (7) begin
            tick(1);
            pulse();
        end
        total++; if (fill_level !== 4'd8) $display("FAIL fp_full: got %0d want 8", fill_level); else passed++;
        tick(1);
        pulse_in = 1'b1;
        iv.iv_ready = 1'b1;
        tick(1);
        pulse_in = 1'b0;
        iv.iv_ready = 1'b0;
        total++; if (fill_level !== 4'd8) $display("FAIL fp_fill: got %0d want 8", fill_level); else passed++;
        total++; if (drop_count !== 8'd0 || overflow !== 1'b0) $display("FAIL fp_nodrop: got %0d/%b want 0/0", drop_count, overflow); else passed++;
        total++; if (iv.iv_first !== 1'b0 || iv.iv_data !== 16'd2) $display("FAIL fp_head: got %b/%0d want 0/2", iv.iv_first, iv.iv_data); else passed++;
        tick(1);
        pulse();
        tick(1);
        pulse();
        total++; if (drop_count !== 8'd2 || overflow !== 1'b1) $display("FAIL fp_drop2: got %0d/%b want 2/1", drop_count, overflow); else passed++;
        tick(1);
        pulse_in = 1'b1;
        clear_stats = 1'b1;
        tick(1);
        pulse_in = 1'b0;
        clear_stats = 1'b0;
        total++; if (drop_count !== 8'd1 || overflow !== 1'b1) $display("FAIL fp_clrdrop: got %0d/%b want 1/1", drop_count, overflow); else passed++;
        clear_stats = 1'b1;
        tick(1);
        clear_stats = 1'b0;
        total++; if (drop_count !== 8'd0 || overflow !== 1'b0) $display("FAIL fp_clear: got %0d/%b want 0/0", drop_count, overflow); else passed++;
    endtask

    task automatic test_disable();
        do_reset();
        enable = 1'b1;
        tick(1);
        pulse();
        tick(1);
        pulse();
        tick(1);
        pulse();
        enable = 1'b0;
        tick(1);
        pulse();
        tick(1);
        pulse();
        tick(1);
        total++; if (fill_level !== 4'd3) $display("FAIL dis_fill: got %0d want 3", fill_level); else passed++;
        iv.iv_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (iv.iv_valid !== 1'b1 || iv.iv_first !== (k == 0) || iv.iv_data !== ((k == 0) ? 16'd0 : 16'd2))
                $display("FAIL dis_drain%0d: got %b/%b/%0d want 1/%b/%0d", k, iv.iv_valid, iv.iv_first, iv.iv_data, (k == 0), (k == 0) ? 0 : 2);
            else passed++;
            tick(1);
        end
        total++; if (iv.iv_valid !== 1'b0) $display("FAIL dis_empty: got %b want 0", iv.iv_valid); else passed++;
        iv.iv_ready = 1'b0;
        enable = 1'b1;
        tick(1);
        pulse();
        total++; if (iv.iv_first !== 1'b1 || iv.iv_data !== 16'd0 || fill_level !== 4'd1) $display("FAIL dis_rearm: got %b/%0d/%0d want 1/0/1", iv.iv_first, iv.iv_data, fill_level); else passed++;
        tick(1);
        pulse();
        total++; if (fill_level !== 4'd2) $display("FAIL dis_fill2: got %0d want 2", fill_level); else passed++;
        reset = 1'b1;
        tick(1);
        total++; if (iv.iv_valid !== 1'b0 || fill_level !== 4'd0) $display("FAIL mid_reset: got %b/%0d want 0/0", iv.iv_valid, fill_level); else passed++;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_intervals();
        test_long_high();
        test_saturate();
        test_overflow();
        test_full_pop();
        test_disable();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipe_pulse_interval_meter.md
# pipe_pulse_interval_meter

Downstream consumer of the pulse pipeline output (`pipe_out` of the last pulse-generator stage). Detects each rising edge on the incoming pulse line, measures the clock-cycle interval since the previous edge, and buffers the results in a small FIFO. The FIFO is drained through a valid/ready handshake to a host or logger. Drops on a full FIFO are reported through a sticky flag and a saturating counter.

## Interface
- `IW`, 16: interval field width in bits; measured intervals saturate at 2^IW-1.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `enable`  in  1  measurement enable; low = no new entries, FIFO still drains.
- `pulse_in`  in  1  pulse line from the upstream pipeline stage, synchronous to `clk`.
- `iv_data`  out  IW  interval of the head entry, in cycles.
- `iv_first`  out  1  head entry is the first edge after arming (no previous edge).
- `iv_valid`  out  1  head entry present.
- `iv_ready`  in  1  consumer accepts the head entry.
- `clear_stats`  in  1  one-cycle clear of `overflow` and `drop_count`.
- `overflow`  out  1  sticky: at least one entry was dropped.
- `drop_count`  out  8  dropped entries, saturating at 255.
- `fill_level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Edge detect: `edge = pulse_in & ~pulse_prev`. `pulse_prev` is a register of `pulse_in`, updated every cycle regardless of `enable`. A multi-cycle high level (back-to-back upstream triggers) counts as one edge.
- States:
  - IDLE: `enable`=0.
  - ARMED: enabled, no edge yet.
  - RUN: at least one edge seen.
- Transitions:
  - IDLE→ARMED when `enable`=1.
  - ARMED→RUN on `edge`.
  - Any state→IDLE when `enable`=0.
- Interval counter `cnt` (IW bits):
  - Cleared to 0 on every accepted edge.
  - Otherwise increments by 1 each cycle in RUN, saturating at 2^IW-1.
  - Held at 0 in IDLE and ARMED.
- Entry on edge in ARMED: {first=1, data=0}.
- Entry on edge in RUN: {first=0, data=min(cnt+1, 2^IW-1)}.
- No entries and no state change from edges while `enable`=0.
- FIFO: first-word-fall-through. A pop occurs when `iv_valid & iv_ready`. Pointers wrap modulo DEPTH.
- Push onto a full FIFO with a pop in the same cycle: both occur, the entry is accepted, and occupancy is unchanged.
- Push onto a full FIFO without a pop: the entry is discarded, `overflow` is set, and `drop_count` is incremented with saturation.
- `clear_stats` zeroes `overflow` and `drop_count`. A drop in the same cycle wins: the result is `overflow`=1, `drop_count`=1.
- Disabling `enable` does not flush the FIFO.
- Reset mid-operation:
  - FIFO is emptied and state returns to IDLE.
  - `cnt`, `pulse_prev`, and the statistics clear.
  - In-flight entries are lost without being counted as drops.

## Timing
- Reset values:
  - `iv_valid`=0, `iv_data`=0, `iv_first`=0.
  - `overflow`=0, `drop_count`=0, `fill_level`=0.
  - State IDLE.
- Latency: for an edge sampled at cycle N (`pulse_in`=1 at N, 0 at N-1) into an empty FIFO, `iv_valid`=1 with that entry from cycle N+1.
- Interval definition: edges at cycles A and B give a data value of B-A. Example: edges at 10 and 15 give 5.
- Minimum edge spacing is 2 cycles, which gives an interval of 2.
- The pop takes effect on the clock edge where `iv_valid & iv_ready`=1. The next entry, if present, appears in the following cycle. Sustained throughput is 1 entry/cycle.
- `iv_data` and `iv_first` are stable while `iv_valid`=1 and `iv_ready`=0.
- `fill_level` reflects the registered occupancy after the last clock edge.
- `enable` rising at cycle N: the FSM is in ARMED from N+1, and edges are recognised from N+1.

## Test plan
- Reset, then `enable`=1, with edges at cycles 10, 15, 115 and `iv_ready`=1 → entries {1,0}, {0,5}, {0,100}, each valid one cycle after its edge.
- `pulse_in` held high for cycles 20–25, then an edge at 40 → exactly two entries: {1,0} and {0,20}.
- IW=4, edges 30 cycles apart → second entry data=15 (saturated).
- `iv_ready`=0 while 10 edges arrive with DEPTH=8 → `fill_level`=8, `overflow`=1, `drop_count`=2. Then drain with `iv_ready`=1 → the 8 oldest entries come out in order, and `iv_data` is stable while stalled.
- FIFO full, edge and pop in the same cycle → entry accepted, `drop_count` unchanged, `fill_level` stays 8. Separately, `clear_stats` coincident with a drop → `overflow`=1, `drop_count`=1.
- `enable` dropped with 3 entries queued → queued entries still drain, and edges during disable produce nothing. Re-enable followed by an edge → {1,0}. Reset asserted with entries queued → `iv_valid`=0 and `fill_level`=0 next cycle.
